// File: rtl/nachi_pkg.sv
// Shared definitions for the register-file slice: register count, address
// width and the hard-wired zero register.
package nachi_pkg;

   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : nachi_pkg

// File: rtl/register_file_if.sv
// Operand/writeback bundle of the register file: one write port and two
// combinational read ports.
interface register_file_if
   import nachi_pkg::*;
#(
   parameter int WIDTH = 32
) ();

   logic             WE;
   reg_addr_t        WA;
   logic [WIDTH-1:0] WD;
   reg_addr_t        RA1;
   reg_addr_t        RA2;
   logic [WIDTH-1:0] RD1;
   logic [WIDTH-1:0] RD2;

   modport master (
      output WE, WA, WD, RA1, RA2,
      input  RD1, RD2
   );

   modport slave (
      input  WE, WA, WD, RA1, RA2,
      output RD1, RD2
   );

endinterface : register_file_if

// File: rtl/ThirtyTwoWayDecoder.sv
// Enable-gated 5-to-32 one-hot decoder; with A low the output is all zero
// whatever S is, so an unknown select cannot raise a strobe.
module ThirtyTwoWayDecoder (
   input  logic        A,
   input  logic [4:0]  S,
   output logic [31:0] F
);

   // One-hot decode of S, qualified by A
   always_comb begin
      F = 32'd0;
      if (A) begin
         F[S] = 1'b1;
      end else begin
         F = 32'd0;
      end
   end

endmodule : ThirtyTwoWayDecoder

// File: rtl/reg_cell.sv
// One register row: WIDTH-bit flop with synchronous clear (dominant) and
// load enable.
module reg_cell #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_r;

   // Row storage: clear beats load
   always_ff @(posedge clk) begin
      if (clr) begin
         q_r <= {WIDTH{1'b0}};
      end else if (en) begin
         q_r <= d;
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule : reg_cell

// File: rtl/register_file.sv
// 32 x WIDTH register file, R0 reads as zero; one synchronous write port and
// two combinational read ports with optional write-to-read bypass.
module register_file
   import nachi_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit BYPASS = 1'b1
) (
   input logic            clk,
   input logic            rst,
   register_file_if.slave rf
);

   logic [NUM_REGS-1:0]            row_we_s;
   logic [NUM_REGS-1:0][WIDTH-1:0] regs_s;
   logic [WIDTH-1:0]               rd1_s;
   logic [WIDTH-1:0]               rd2_s;
   logic                           unused_row0_s;

   ThirtyTwoWayDecoder u_dec (
      .A (rf.WE),
      .S (rf.WA),
      .F (row_we_s)
   );

   // R0 has no storage; its strobe is deliberately dropped
   assign unused_row0_s = row_we_s[0];
   assign regs_s[0]     = {WIDTH{1'b0}};

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_row
      reg_cell #(
         .WIDTH (WIDTH)
      ) u_cell (
         .clk (clk),
         .clr (rst),
         .en  (row_we_s[i]),
         .d   (rf.WD),
         .q   (regs_s[i])
      );
   end

   // Read port 1: reset and R0 force zero, then bypass, then stored value
   always_comb begin
      rd1_s = {WIDTH{1'b0}};
      if (rst || (rf.RA1 == ZERO_REG)) begin
         rd1_s = {WIDTH{1'b0}};
      end else if ((BYPASS != 1'b0) && rf.WE && (rf.WA == rf.RA1)) begin
         rd1_s = rf.WD;
      end else begin
         rd1_s = regs_s[rf.RA1];
      end
   end

   // Read port 2: same priority as port 1
   always_comb begin
      rd2_s = {WIDTH{1'b0}};
      if (rst || (rf.RA2 == ZERO_REG)) begin
         rd2_s = {WIDTH{1'b0}};
      end else if ((BYPASS != 1'b0) && rf.WE && (rf.WA == rf.RA2)) begin
         rd2_s = rf.WD;
      end else begin
         rd2_s = regs_s[rf.RA2];
      end
   end

   assign rf.RD1 = rd1_s;
   assign rf.RD2 = rd2_s;

endmodule : register_file
